// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and default parameters for the clock-gate enable controller.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    WAKE  = 2'b01,
    ON    = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_IDLE_CYCLES = 4;
  localparam int DEF_CNT_WIDTH   = 4;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Request/status bundle between the system controller and the clock-gate enable controller.
// Test_Mode exists only when CLK_GATE_CTRL_TEST_MODE_EN is defined.
interface clk_gate_ctrl_if;
  logic Req;
  logic Busy;
  logic Gate_EN;
  logic Ready;
`ifdef CLK_GATE_CTRL_TEST_MODE_EN
  logic Test_Mode;
`endif

  modport master (
    output Req,
    output Busy,
`ifdef CLK_GATE_CTRL_TEST_MODE_EN
    output Test_Mode,
`endif
    input  Gate_EN,
    input  Ready
  );

  modport slave (
    input  Req,
    input  Busy,
`ifdef CLK_GATE_CTRL_TEST_MODE_EN
    input  Test_Mode,
`endif
    output Gate_EN,
    output Ready
  );
endinterface

// File: rtl/clk_gate_ctrl_gate_timer.sv
// Loadable down-counter shared by the wake and drain countdowns; saturates at zero.
module gate_timer #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable controller for a latch-based clock gate: wakes on Req, reports Ready, gates off after idle.
// Optional CLK_GATE_CTRL_TEST_MODE_EN adds Test_Mode, which forces Gate_EN high after the register.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic            CLK,
  input  logic            RST,
  clk_gate_ctrl_if.slave  ifc
);

  localparam logic [CNT_WIDTH-1:0] WAKE_LOAD = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] IDLE_LOAD = CNT_WIDTH'(IDLE_CYCLES - 1);

  if (WAKE_CYCLES < 1 || WAKE_CYCLES > (1 << CNT_WIDTH)) begin : g_bad_wake
    $error("clk_gate_ctrl: WAKE_CYCLES out of range 1..2**CNT_WIDTH");
  end
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > (1 << CNT_WIDTH)) begin : g_bad_idle
    $error("clk_gate_ctrl: IDLE_CYCLES out of range 1..2**CNT_WIDTH");
  end

  state_t               state;
  logic                 gate_en_q;
  logic                 ready_q;
  logic                 active;
  logic                 tmr_load;
  logic                 tmr_dec;
  logic                 tmr_zero;
  logic [CNT_WIDTH-1:0] tmr_load_val;

  assign active = ifc.Req | ifc.Busy;

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    case (state)
      OFF: begin
        tmr_load     = ifc.Req;
        tmr_load_val = WAKE_LOAD;
      end
      WAKE:  tmr_dec = 1'b1;
      ON: begin
        tmr_load     = ~active;
        tmr_load_val = IDLE_LOAD;
      end
      DRAIN: tmr_dec = ~active;
      default: ;
    endcase
  end

  gate_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Outputs are registered next to the state so Gate_EN never sees a Req/Busy glitch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= OFF;
      gate_en_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state)
        OFF: if (ifc.Req) begin
          state     <= WAKE;
          gate_en_q <= 1'b1;
          ready_q   <= 1'b0;
        end
        WAKE: if (tmr_zero) begin
          state   <= ON;
          ready_q <= 1'b1;
        end
        ON: if (!active) begin
          state <= DRAIN;
        end
        DRAIN: begin
          // Activity wins over an expiring countdown in the same cycle.
          if (active) begin
            state <= ON;
          end else if (tmr_zero) begin
            state     <= OFF;
            gate_en_q <= 1'b0;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state     <= OFF;
          gate_en_q <= 1'b0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_GATE_CTRL_TEST_MODE_EN
  assign ifc.Gate_EN = gate_en_q | ifc.Test_Mode;
`else
  assign ifc.Gate_EN = gate_en_q;
`endif
  assign ifc.Ready = ready_q;

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Enable controller that drives the `Enable` input of the system's latch-based clock gate. It turns a gated clock domain (e.g. ALU, register file) on when a requester asks for it. It reports when that domain's clock is stable, and turns the domain off again after a programmable idle period. It sits in the always-on `CLK` domain, between the system controller's request/busy signals and the clock gate cell.

## Interface
- `WAKE_CYCLES`, default 2: cycles from `Gate_EN` rising to `Ready` rising; legal range 1 .. 2^`CNT_WIDTH`.
- `IDLE_CYCLES`, default 4: idle countdown length before gating off; legal range 1 .. 2^`CNT_WIDTH`.
- `CNT_WIDTH`, default 4: width of the shared countdown timer.
- `CLK`  in  1  free-running (ungated) system clock.
- `RST`  in  1  asynchronous, active-high reset.
- `Req`  in  1  requester wants the gated domain clocked; synchronous to `CLK`.
- `Busy`  in  1  gated domain still has work in flight; synchronous to `CLK`.
- `Gate_EN`  out  1  to clock-gate `Enable`; registered, glitch-free.
- `Ready`  out  1  gated clock stable; requester may issue work.

## Operation
- Four-state FSM: OFF, WAKE, ON, DRAIN. Reset state is OFF.
- Reset values: `Gate_EN`=0, `Ready`=0, timer=0.
- OFF:
  - Outputs `Gate_EN`=0, `Ready`=0.
  - `Req`=1 → WAKE; timer loads `WAKE_CYCLES`-1.
  - `Busy` alone does not wake the domain.
- WAKE:
  - Outputs `Gate_EN`=1, `Ready`=0.
  - Timer decrements each cycle.
  - Timer==0 → ON.
  - `Req` dropping during WAKE does not abort the wake; the FSM still reaches ON and then drains normally.
- ON:
  - Outputs `Gate_EN`=1, `Ready`=1.
  - `Req`=0 and `Busy`=0 → DRAIN; timer loads `IDLE_CYCLES`-1.
- DRAIN:
  - Outputs `Gate_EN`=1, `Ready`=1.
  - `Req` or `Busy` high → ON; the countdown is discarded.
  - Otherwise the timer decrements; timer==0 and still idle → OFF.
  - Activity has priority over expiry when both happen in the same cycle.
- Both outputs are decoded from registered state only. There is no combinational path from `Req`/`Busy` to `Gate_EN`.
- Timer arithmetic:
  - Unsigned, saturating at 0; it never wraps.
  - Parameter values outside the legal range are a configuration error and are flagged by an elaboration-time check.
- Reset mid-operation (any state):
  - `RST` forces OFF and `Gate_EN`=0 asynchronously.
  - The downstream latch holds its enable while `CLK` is high, so an in-progress gated pulse completes cleanly.

## Timing
- Wake latency: `Req` sampled high at edge k → `Gate_EN`=1 after edge k, `Ready`=1 after edge k+`WAKE_CYCLES`.
- Gate-off latency: let m be the last edge at which `Req`|`Busy` is sampled high. Then `Gate_EN` and `Ready` both fall after edge m+1+`IDLE_CYCLES`.
- `Req` re-asserted in the same cycle as the OFF transition: the FSM enters OFF, then moves to WAKE on the next edge (minimum one-cycle off window).
- Back-to-back requests during ON/DRAIN add no latency; `Ready` stays high.

## Configuration
- `CLK_GATE_CTRL_TEST_MODE_EN` defined:
  - Adds input `Test_Mode` (1 bit).
  - `Test_Mode`=1 forces `Gate_EN`=1 via an OR after the output register, so scan shift/capture reaches the gated domain.
  - FSM and `Ready` are unaffected.
- `CLK_GATE_CTRL_TEST_MODE_EN` undefined: no `Test_Mode` port; `Gate_EN` comes from the FSM only.

## Structure
- Package `clk_gate_ctrl_pkg` holds:
  - State typedef: OFF=2'b00, WAKE=2'b01, ON=2'b10, DRAIN=2'b11.
  - Default values of `WAKE_CYCLES`, `IDLE_CYCLES` and `CNT_WIDTH`.
- Sub-module `gate_timer`:
  - Loadable `CNT_WIDTH` down-counter with `load`, `load_val`, `dec` inputs and a `zero` output.
  - A single instance is shared by WAKE and DRAIN.

## Test plan
- Reset then idle 10 cycles, `Req`=0 → `Gate_EN`=0, `Ready`=0 throughout.
- Defaults, `Req` high at edge 5 → `Gate_EN` high after edge 5, `Ready` high after edge 7.
- `Req` held high to edge 9, then low, `Busy`=0 → DRAIN after edge 10, `Gate_EN`/`Ready` low after edge 14.
- `Busy` pulses in DRAIN at timer=1 → back to ON, `Gate_EN` never drops; a later idle gives the full 4-cycle countdown.
- `RST` asserted mid-WAKE and mid-DRAIN → `Gate_EN`=0 immediately; after release, `Req` gives the same 2-cycle wake.
- With `CLK_GATE_CTRL_TEST_MODE_EN`, `Test_Mode`=1 in OFF → `Gate_EN`=1, `Ready`=0, state stays OFF.
